// File: rtl/lc3_mem_arbiter_if.sv
// Core-side and memory-side signals of the LC3 fetch/data memory arbiter.
// slave = arbiter view; master = the core plus memory that surround it.
interface lc3_mem_arbiter_if;
  logic        i_macc;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic        d_macc;
  logic        data_rd;
  logic [15:0] data_addr;
  logic [15:0] data_din;
  logic [15:0] instr_dout;
  logic [15:0] data_dout;
  logic        complete_instr;
  logic        complete_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        arb_timeout;

  modport slave (
    input  i_macc, instrmem_rd, pc, d_macc, data_rd, data_addr, data_din,
    input  mem_rdata, mem_ack,
    output instr_dout, data_dout, complete_instr, complete_data,
    output mem_req, mem_we, mem_addr, mem_wdata, arb_timeout
  );

  modport master (
    output i_macc, instrmem_rd, pc, d_macc, data_rd, data_addr, data_din,
    output mem_rdata, mem_ack,
    input  instr_dout, data_dout, complete_instr, complete_data,
    input  mem_req, mem_we, mem_addr, mem_wdata, arb_timeout
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Serialises LC3 fetch and data accesses onto one memory port; ties go round-robin with LC3_ARB_RR_EN, else data-first.
// Latency: request to complete_x is 2 cycles minimum, TIMEOUT+1 cycles when mem_ack never comes.
// Backpressure: requesters stall by holding macc; memory stalls by withholding mem_ack, bounded by TIMEOUT.
module lc3_mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  lc3_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        req_i;
  logic        req_d;
  logic        pick_d;
  logic        wait_over;

  // A requester still showing its complete pulse cannot be re-granted.
  assign req_i     = bus.i_macc & bus.instrmem_rd & ~bus.complete_instr;
  assign req_d     = bus.d_macc & ~bus.complete_data;
  assign wait_over = (wait_cnt == WAIT_LAST);

`ifdef LC3_ARB_RR_EN
  logic last_d;

  assign pick_d = req_d & (~req_i | ~last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (req_i | req_d)) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = req_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      wait_cnt           <= 16'h0000;
      bus.mem_req        <= 1'b0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= 16'h0000;
      bus.mem_wdata      <= 16'h0000;
      bus.instr_dout     <= 16'h0000;
      bus.data_dout      <= 16'h0000;
      bus.complete_instr <= 1'b0;
      bus.complete_data  <= 1'b0;
      bus.arb_timeout    <= 1'b0;
    end else begin
      bus.complete_instr <= 1'b0;
      bus.complete_data  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i | req_d) begin
            state       <= pick_d ? BUSY_D : BUSY_I;
            wait_cnt    <= 16'h0000;
            bus.mem_req <= 1'b1;
            bus.mem_addr  <= pick_d ? bus.data_addr : bus.pc;
            bus.mem_we    <= pick_d & ~bus.data_rd;
            bus.mem_wdata <= pick_d ? bus.data_din : 16'h0000;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ack) begin
            state       <= DONE;
            bus.mem_req <= 1'b0;
            if (state == BUSY_I) begin
              bus.instr_dout     <= bus.mem_rdata;
              bus.complete_instr <= 1'b1;
            end else begin
              // Writes leave data_dout holding the last read value.
              if (!bus.mem_we) begin
                bus.data_dout <= bus.mem_rdata;
              end
              bus.complete_data <= 1'b1;
            end
          end else if (wait_over) begin
            state           <= DONE;
            bus.mem_req     <= 1'b0;
            bus.arb_timeout <= 1'b1;
            if (state == BUSY_I) begin
              bus.instr_dout     <= 16'h0000;
              bus.complete_instr <= 1'b1;
            end else begin
              bus.data_dout     <= 16'h0000;
              bus.complete_data <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'h0001;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Randomised fetch/data traffic against a transaction-level arbiter model, then a mid-access reset.
module tb_lc3_mem_arbiter;
  localparam int TMO    = 4;
  localparam int N_RAND = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lc3_mem_arbiter_if bus ();

  lc3_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Model state: one outstanding access at a time, described by its grant cycle and ack delay.
  bit          pend_i, pend_d, busy, who_d, pick_d, drained;
  bit          rel_i, rel_d, exp_req, exp_ci, exp_cd;
  int          g_cyc, done_cyc, free_cyc, dly;
  logic [15:0] l_addr, l_wdata, ack_data, e_idout, e_ddout;
  bit          l_we, l_rd, e_tmo;
`ifdef LC3_ARB_RR_EN
  bit          last_d;
`endif

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(bus.mem_req), 32'd0);
    chk({tag, "_we"},    32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_idout"}, 32'(bus.instr_dout), 32'd0);
    chk({tag, "_ddout"}, 32'(bus.data_dout), 32'd0);
    chk({tag, "_ci"},    32'(bus.complete_instr), 32'd0);
    chk({tag, "_cd"},    32'(bus.complete_data), 32'd0);
    chk({tag, "_tmo"},   32'(bus.arb_timeout), 32'd0);
  endtask

  initial begin
    bus.i_macc = 1'b0; bus.instrmem_rd = 1'b0; bus.pc = 16'h0000;
    bus.d_macc = 1'b0; bus.data_rd = 1'b0; bus.data_addr = 16'h0000; bus.data_din = 16'h0000;
    bus.mem_rdata = 16'h0000; bus.mem_ack = 1'b0;
    pend_i = 0; pend_d = 0; busy = 0; who_d = 0; free_cyc = 0; drained = 0;
    g_cyc = 0; done_cyc = 0; dly = 0;
    l_addr = 0; l_wdata = 0; l_we = 0; l_rd = 0; ack_data = 0;
    e_idout = 0; e_ddout = 0; e_tmo = 0;
`ifdef LC3_ARB_RR_EN
    last_d = 1;
`endif

    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int n = 0; n < N_RAND + 400; n++) begin
      if (n > 0) @(negedge clk);
      rel_i = 0;
      rel_d = 0;

      // Retire the access whose complete pulse is due this cycle.
      exp_ci = busy && n == done_cyc && !who_d;
      exp_cd = busy && n == done_cyc && who_d;
      if (busy && n == done_cyc) begin
        if (dly >= TMO) begin
          e_tmo = 1;
          if (who_d) e_ddout = 16'h0000; else e_idout = 16'h0000;
        end else if (!who_d) begin
          e_idout = ack_data;
        end else if (l_rd) begin
          e_ddout = ack_data;
        end
      end
      exp_req = busy && n > g_cyc && n < done_cyc;

      chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("mem_addr",  32'(bus.mem_addr), 32'(l_addr));
        chk("mem_we",    32'(bus.mem_we), 32'(l_we));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(l_wdata));
      end
      chk("complete_instr", 32'(bus.complete_instr), 32'(exp_ci));
      chk("complete_data",  32'(bus.complete_data), 32'(exp_cd));
      chk("instr_dout",     32'(bus.instr_dout), 32'(e_idout));
      chk("data_dout",      32'(bus.data_dout), 32'(e_ddout));
      chk("arb_timeout",    32'(bus.arb_timeout), 32'(e_tmo));

      if (busy && n == done_cyc) begin
        busy = 0;
        free_cyc = n + 1;
        if (who_d) begin
          pend_d = 0; rel_d = 1; bus.d_macc = 1'b0;
        end else begin
          pend_i = 0; rel_i = 1; bus.i_macc = 1'b0; bus.instrmem_rd = 1'b0;
        end
      end

      // Requesters: raise, idle noise (i_macc without instrmem_rd), or scramble fields once granted.
      if (!pend_i && !rel_i) begin
        if (n < N_RAND && $urandom_range(0, 3) == 0) begin
          pend_i = 1; bus.i_macc = 1'b1; bus.instrmem_rd = 1'b1; bus.pc = 16'($urandom);
        end else begin
          bus.i_macc = 1'($urandom_range(0, 1)); bus.instrmem_rd = 1'b0; bus.pc = 16'($urandom);
        end
      end else if (busy && !who_d && n > g_cyc) begin
        bus.pc = 16'($urandom);
      end
      if (!pend_d && !rel_d) begin
        if (n < N_RAND && $urandom_range(0, 3) == 0) begin
          pend_d = 1; bus.d_macc = 1'b1;
        end else begin
          bus.d_macc = 1'b0;
        end
        bus.data_rd = 1'($urandom_range(0, 1));
        bus.data_addr = 16'($urandom); bus.data_din = 16'($urandom);
      end else if (busy && who_d && n > g_cyc) begin
        bus.data_rd = 1'($urandom_range(0, 1));
        bus.data_addr = 16'($urandom); bus.data_din = 16'($urandom);
      end

      // Memory: ack exactly at the chosen delay, random stray acks whenever no access is open.
      bus.mem_rdata = 16'($urandom);
      if (busy && n > g_cyc && n < done_cyc) begin
        if (dly < TMO && n == g_cyc + 1 + dly) begin
          bus.mem_ack = 1'b1; ack_data = bus.mem_rdata;
        end else begin
          bus.mem_ack = 1'b0;
        end
      end else begin
        bus.mem_ack = ($urandom_range(0, 3) == 0);
      end

      if (!busy && n >= free_cyc && (pend_i || pend_d)) begin
`ifdef LC3_ARB_RR_EN
        pick_d = pend_d && (!pend_i || !last_d);
        last_d = pick_d;
`else
        pick_d = pend_d;
`endif
        busy = 1; who_d = pick_d; g_cyc = n;
        dly = $urandom_range(0, TMO + 1);
        done_cyc = n + 2 + ((dly < TMO) ? dly : TMO - 1);
        if (pick_d) begin
          l_addr = bus.data_addr; l_rd = bus.data_rd; l_we = !bus.data_rd; l_wdata = bus.data_din;
        end else begin
          l_addr = bus.pc; l_rd = 1; l_we = 0; l_wdata = 16'h0000;
        end
      end

      if (n >= N_RAND && !busy && !pend_i && !pend_d) begin
        drained = 1;
        break;
      end
    end
    chk("drain", 32'(drained), 32'd1);

    // Reset during an instruction access, with a data request waiting behind it.
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.d_macc = 1'b0;
    bus.i_macc = 1'b1; bus.instrmem_rd = 1'b1; bus.pc = 16'h3000;
    @(negedge clk);
    chk("rst_pre_req",  32'(bus.mem_req), 32'd1);
    chk("rst_pre_addr", 32'(bus.mem_addr), 32'h3000);
    bus.d_macc = 1'b1; bus.data_rd = 1'b1; bus.data_addr = 16'h5000;
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    bus.i_macc = 1'b0; bus.instrmem_rd = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ci",  32'(bus.complete_instr), 32'd0);
      chk("rst_hold_req", 32'(bus.mem_req), 32'd0);
    end
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hCAFE;
    @(negedge clk);
    chk("post_rst_req",  32'(bus.mem_req), 32'd1);
    chk("post_rst_addr", 32'(bus.mem_addr), 32'h5000);
    chk("post_rst_we",   32'(bus.mem_we), 32'd0);
    chk("post_rst_cd0",  32'(bus.complete_data), 32'd0);
    @(negedge clk);
    chk("post_rst_cd",    32'(bus.complete_data), 32'd1);
    chk("post_rst_ddout", 32'(bus.data_dout), 32'hCAFE);
    chk("post_rst_ci",    32'(bus.complete_instr), 32'd0);
    chk("post_rst_idout", 32'(bus.instr_dout), 32'd0);
    chk("post_rst_tmo",   32'(bus.arb_timeout), 32'd0);
    bus.d_macc = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_cd_end", 32'(bus.complete_data), 32'd0);
    chk("post_rst_req_end", 32'(bus.mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
